// File: rtl/seq_adder_n_if.sv
// seq_adder_n_if: start/done handshake and operand/result bundle for seq_adder_n.
// The sub signal only exists when SEQ_ADDER_SUB_EN is defined.
interface seq_adder_n_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
`ifdef SEQ_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             ovf;

`ifdef SEQ_ADDER_SUB_EN
    modport master (
        output start, A, B, Cin, sub,
        input  busy, done, Sum, Cout, ovf
    );

    modport slave (
        input  start, A, B, Cin, sub,
        output busy, done, Sum, Cout, ovf
    );
`else
    modport master (
        output start, A, B, Cin,
        input  busy, done, Sum, Cout, ovf
    );

    modport slave (
        input  start, A, B, Cin,
        output busy, done, Sum, Cout, ovf
    );
`endif
endinterface

// File: rtl/seq_adder_n.sv
// seq_adder_n: multi-cycle adder, SLICE bits per clock with a registered carry
// between slices. Operands are captured on an accepted start; Sum/Cout/ovf
// update only when an operation completes, flagged by a one-cycle done pulse.
// Optional feature macro: SEQ_ADDER_SUB_EN adds a sub input (A - B via ~B and
// an inverted carry-in).
module seq_adder_n #(
    parameter int WIDTH = 8,
    parameter int SLICE = 1
) (
    input logic         clk,
    input logic         reset,
    seq_adder_n_if.slave bus
);
    localparam int STEPS = WIDTH / SLICE;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    generate
        if (WIDTH < 2 || SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_bad_params
            $error("seq_adder_n: need WIDTH >= 2, 1 <= SLICE <= WIDTH and WIDTH %% SLICE == 0");
        end
    endgenerate

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    state_t           nextState;

    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] sumReg;
    logic             carry;
    logic             aMsb;
    logic             bMsb;
    logic             coutReg;
    logic             ovfReg;
    logic             doneReg;
    logic [CW-1:0]    count;

    logic             subSel;
    logic [WIDTH-1:0] bEff;
    logic             cEff;
    logic             accept;
    logic             lastStep;
    logic [SLICE:0]   sliceSum;
    logic [WIDTH-1:0] nextPartial;

`ifdef SEQ_ADDER_SUB_EN
    assign subSel = bus.sub;
`else
    assign subSel = 1'b0;
`endif

    // Subtraction is A + ~B with the carry-in inverted; plain add when subSel is low.
    assign bEff     = bus.B ^ {WIDTH{subSel}};
    assign cEff     = bus.Cin ^ subSel;
    assign accept   = (state == IDLE) && bus.start;
    assign lastStep = (state == RUN) && (count == LAST);

    assign sliceSum    = {1'b0, opA[SLICE-1:0]} + {1'b0, opB[SLICE-1:0]} + {{SLICE{1'b0}}, carry};
    assign nextPartial = (partial >> SLICE) | (WIDTH'(sliceSum[SLICE-1:0]) << (WIDTH - SLICE));

    // State register; reset overrides any pending start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state: leave IDLE on start, return after the final slice.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (bus.start) nextState = RUN;
            RUN:     if (count == LAST) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, add one slice per RUN cycle, publish on the last.
    always_ff @(posedge clk) begin
        if (reset) begin
            opA     <= '0;
            opB     <= '0;
            partial <= '0;
            sumReg  <= '0;
            carry   <= 1'b0;
            aMsb    <= 1'b0;
            bMsb    <= 1'b0;
            coutReg <= 1'b0;
            ovfReg  <= 1'b0;
            doneReg <= 1'b0;
            count   <= '0;
        end else begin
            doneReg <= 1'b0;
            if (accept) begin
                opA     <= bus.A;
                opB     <= bEff;
                carry   <= cEff;
                aMsb    <= bus.A[WIDTH-1];
                bMsb    <= bEff[WIDTH-1];
                partial <= '0;
                count   <= '0;
            end else if (state == RUN) begin
                opA     <= opA >> SLICE;
                opB     <= opB >> SLICE;
                carry   <= sliceSum[SLICE];
                partial <= nextPartial;
                count   <= count + 1'b1;
                if (lastStep) begin
                    sumReg  <= nextPartial;
                    coutReg <= sliceSum[SLICE];
                    ovfReg  <= (aMsb == bMsb) && (nextPartial[WIDTH-1] != aMsb);
                    doneReg <= 1'b1;
                end
            end
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = doneReg;
    assign bus.Sum  = sumReg;
    assign bus.Cout = coutReg;
    assign bus.ovf  = ovfReg;
endmodule

// File: tb/tb_seq_adder_n.sv
// tb_seq_adder_n: four seq_adder_n instances (4/1, 8/2, 8/8, 8/1) driven from a
// shared stimulus bus and checked against an integer-arithmetic reference model.
module tb_seq_adder_n;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] stimA;
    logic [7:0] stimB;
    logic       stimCin;
`ifdef SEQ_ADDER_SUB_EN
    logic       stimSub;
`endif
    logic       startV [4];
    logic       busyV  [4];
    logic       doneV  [4];
    logic [7:0] sumV   [4];
    logic       coutV  [4];
    logic       ovfV   [4];

    logic [7:0] expSum  [4];
    logic       expCout [4];
    logic       expOvf  [4];
    int         widthV  [4] = '{4, 8, 8, 8};
    int         stepsV  [4] = '{4, 4, 1, 8};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_adder_n_if #(.WIDTH(4)) if0 ();
    seq_adder_n_if #(.WIDTH(8)) if1 ();
    seq_adder_n_if #(.WIDTH(8)) if2 ();
    seq_adder_n_if #(.WIDTH(8)) if3 ();

    assign if0.start = startV[0];
    assign if1.start = startV[1];
    assign if2.start = startV[2];
    assign if3.start = startV[3];
    assign if0.A = stimA[3:0];
    assign if0.B = stimB[3:0];
    assign if1.A = stimA;
    assign if1.B = stimB;
    assign if2.A = stimA;
    assign if2.B = stimB;
    assign if3.A = stimA;
    assign if3.B = stimB;
    assign if0.Cin = stimCin;
    assign if1.Cin = stimCin;
    assign if2.Cin = stimCin;
    assign if3.Cin = stimCin;
`ifdef SEQ_ADDER_SUB_EN
    assign if0.sub = stimSub;
    assign if1.sub = stimSub;
    assign if2.sub = stimSub;
    assign if3.sub = stimSub;
`endif

    assign busyV[0] = if0.busy;
    assign busyV[1] = if1.busy;
    assign busyV[2] = if2.busy;
    assign busyV[3] = if3.busy;
    assign doneV[0] = if0.done;
    assign doneV[1] = if1.done;
    assign doneV[2] = if2.done;
    assign doneV[3] = if3.done;
    assign sumV[0]  = {4'b0000, if0.Sum};
    assign sumV[1]  = if1.Sum;
    assign sumV[2]  = if2.Sum;
    assign sumV[3]  = if3.Sum;
    assign coutV[0] = if0.Cout;
    assign coutV[1] = if1.Cout;
    assign coutV[2] = if2.Cout;
    assign coutV[3] = if3.Cout;
    assign ovfV[0]  = if0.ovf;
    assign ovfV[1]  = if1.ovf;
    assign ovfV[2]  = if2.ovf;
    assign ovfV[3]  = if3.ovf;

    seq_adder_n #(.WIDTH(4), .SLICE(1)) u0 (.clk(clk), .reset(reset), .bus(if0));
    seq_adder_n #(.WIDTH(8), .SLICE(2)) u1 (.clk(clk), .reset(reset), .bus(if1));
    seq_adder_n #(.WIDTH(8), .SLICE(8)) u2 (.clk(clk), .reset(reset), .bus(if2));
    seq_adder_n #(.WIDTH(8), .SLICE(1)) u3 (.clk(clk), .reset(reset), .bus(if3));

    task automatic checkOutput(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: whole-word integer addition and a signed range test for overflow.
    task automatic refModel(input int w, input logic [7:0] a, input logic [7:0] b,
                            input logic cin, input logic sb,
                            output logic [7:0] s, output logic co, output logic ov);
        int mask, av, bv, c, total, sa, sbv, sr, half;
        mask  = (1 << w) - 1;
        half  = 1 << (w - 1);
        av    = int'(a) & mask;
        bv    = sb ? (~int'(b) & mask) : (int'(b) & mask);
        c     = int'(cin ^ sb);
        total = av + bv + c;
        s     = 8'(total & mask);
        co    = 1'((total >> w) & 1);
        sa    = (av >= half) ? av - (1 << w) : av;
        sbv   = (bv >= half) ? bv - (1 << w) : bv;
        sr    = sa + sbv + c;
        ov    = (sr > half - 1) || (sr < -half);
    endtask

    task automatic checkHeld(input int d, input string tag);
        checkOutput({tag, "_sum"}, int'(sumV[d]), int'(expSum[d]));
        checkOutput({tag, "_cout"}, int'(coutV[d]), int'(expCout[d]));
        checkOutput({tag, "_ovf"}, int'(ovfV[d]), int'(expOvf[d]));
    endtask

    // Starts an operation at a negedge and returns at the negedge where done is seen.
    task automatic applyStimulus(input int d, input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, input logic sb,
                                 input logic hold, input logic [7:0] holdA);
        logic [7:0] ns;
        logic       nc, nv;
        int         lat;
        bit         seen;
        stimA   = a;
        stimB   = b;
        stimCin = cin;
`ifdef SEQ_ADDER_SUB_EN
        stimSub = sb;
`endif
        startV[d] = 1'b1;
        refModel(widthV[d], a, b, cin, sb, ns, nc, nv);
        @(posedge clk);
        @(negedge clk);
        if (hold) begin
            stimA = holdA;
        end else begin
            startV[d] = 1'b0;
            stimA = 8'($urandom);
        end
        stimB   = 8'($urandom);
        stimCin = 1'($urandom);
`ifdef SEQ_ADDER_SUB_EN
        stimSub = 1'($urandom);
`endif
        checkOutput("busy_after_start", int'(busyV[d]), 1);
        checkOutput("no_early_done", int'(doneV[d]), 0);
        lat  = 0;
        seen = 0;
        while (!seen && lat < stepsV[d] + 3) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (doneV[d]) begin
                seen = 1;
            end else begin
                checkOutput("busy_running", int'(busyV[d]), 1);
                checkHeld(d, "hold_while_busy");
            end
        end
        checkOutput("latency", lat, stepsV[d]);
        checkOutput("busy_at_done", int'(busyV[d]), 0);
        expSum[d]  = ns;
        expCout[d] = nc;
        expOvf[d]  = nv;
        checkHeld(d, "result");
        startV[d] = 1'b0;
    endtask

    task automatic idleCycle(input int d);
        @(posedge clk);
        @(negedge clk);
        checkOutput("done_pulse_width", int'(doneV[d]), 0);
        checkOutput("idle_busy", int'(busyV[d]), 0);
        checkHeld(d, "idle_hold");
    endtask

    task automatic clearExpected();
        for (int d = 0; d < 4; d++) begin
            expSum[d]  = '0;
            expCout[d] = 1'b0;
            expOvf[d]  = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int doneCount;
        logic sb;
        for (int d = 0; d < 4; d++) startV[d] = 1'b0;
        stimA   = '0;
        stimB   = '0;
        stimCin = 1'b0;
`ifdef SEQ_ADDER_SUB_EN
        stimSub = 1'b0;
`endif
        clearExpected();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int d = 0; d < 4; d++) begin
            checkOutput("reset_busy", int'(busyV[d]), 0);
            checkOutput("reset_done", int'(doneV[d]), 0);
            checkHeld(d, "reset");
        end

        $display("[TB] 4-bit serial adds");
        applyStimulus(0, 8'd5, 8'd3, 1'b0, 1'b0, 1'b0, 8'h00);
        idleCycle(0);
        applyStimulus(0, 8'd15, 8'd1, 1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(0, 8'd7, 8'd8, 1'b1, 1'b0, 1'b0, 8'h00);
        idleCycle(0);

        $display("[TB] start held during busy is ignored");
        applyStimulus(1, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 8'h10);
        repeat (3) idleCycle(1);

        $display("[TB] back-to-back single step");
        applyStimulus(2, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(2, 8'h40, 8'h40, 1'b0, 1'b0, 1'b0, 8'h00);
        idleCycle(2);

        $display("[TB] reset in the middle of an operation");
        applyStimulus(3, 8'hA5, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h00);
        idleCycle(3);
        stimA = 8'h77;
        stimB = 8'h11;
        startV[3] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        startV[3] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        clearExpected();
        checkOutput("midrun_reset_busy", int'(busyV[3]), 0);
        checkOutput("midrun_reset_done", int'(doneV[3]), 0);
        checkHeld(3, "midrun_reset");
        doneCount = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (doneV[3]) doneCount++;
        end
        checkOutput("abandoned_done_pulses", doneCount, 0);
        applyStimulus(3, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 8'h00);
        idleCycle(3);

`ifdef SEQ_ADDER_SUB_EN
        $display("[TB] subtraction");
        applyStimulus(0, 8'd3, 8'd5, 1'b0, 1'b1, 1'b0, 8'h00);
        idleCycle(0);
        applyStimulus(0, 8'd5, 8'd3, 1'b0, 1'b1, 1'b0, 8'h00);
        idleCycle(0);
`endif

        $display("[TB] randomized operations");
        for (int d = 0; d < 4; d++) begin
            for (int n = 0; n < 15; n++) begin
`ifdef SEQ_ADDER_SUB_EN
                sb = 1'($urandom);
`else
                sb = 1'b0;
`endif
                applyStimulus(d, 8'($urandom), 8'($urandom), 1'($urandom), sb, 1'b0, 8'h00);
                if ($urandom_range(1, 0) == 1) idleCycle(d);
            end
            idleCycle(d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
